// File: rtl/bnn_pkg.sv
// Shared definitions for the BNN result serializer: FSM state encoding,
// default frame/baud parameters and the collector fill-count width.
// Optional build macro used by the design: BNN_TX_PARITY_EN.
package bnn_pkg;

    // Default number of result bits per frame and clocks per serial bit
    localparam int DEF_FRAME_BITS   = 8;
    localparam int DEF_CLKS_PER_BIT = 4;

    // Width of fill_count; holds 0..16
    localparam int FILL_W = 5;

    // Serializer states; PARITY is only visited when BNN_TX_PARITY_EN is set
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // Bit-timer counter width; a one-clock bit period still needs one bit
    function automatic int timer_width(input int clks);
        return (clks > 1) ? $clog2(clks) : 1;
    endfunction

endpackage

// File: rtl/bnn_tx_bit_timer.sv
// Bit-period timer for the serializer. Counts 0..CLKS_PER_BIT-1 while
// enabled, wraps on its own at the end of each bit period, and is held at
// zero by restart so every state entered from IDLE starts a full period.
// bit_end marks the last clock of the current bit period.
module bnn_tx_bit_timer
    import bnn_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    localparam int CW = timer_width(CLKS_PER_BIT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          restart,
    input  logic          enable,
    output logic [CW-1:0] count,
    output logic          bit_end
);

    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    // Free-running period counter, cleared by reset or restart
    always_ff @(posedge clk) begin
        if (!rst_n || restart) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    assign bit_end = enable && (count == LAST);

endmodule

// File: rtl/bnn_result_tx.sv
// BNN result transmitter: collects single result bits from a valid/ready
// stream into a FRAME_BITS-wide frame (first bit accepted = frame bit 0)
// and sends each frame on a UART-like line: start 0, data LSB first,
// optional even parity (build macro BNN_TX_PARITY_EN), stop 1.
//
// Handshake: a bit transfers on a rising edge where res_valid and res_ready
// are both high; res_ready is simply "collector not full", so it never
// depends on res_valid. The collector keeps filling while a previous frame
// is on the line and stalls only once it holds a complete frame.
module bnn_result_tx
    import bnn_pkg::*;
#(
    parameter int FRAME_BITS   = DEF_FRAME_BITS,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       res_valid,
    input  logic       res_bit,
    output logic       res_ready,
    output logic       tx_out,
    output logic       tx_busy,
    output logic       frame_done,
    output logic [4:0] fill_count,
    output logic [2:0] fsm_state
);

    localparam int TW = timer_width(CLKS_PER_BIT);

    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(FRAME_BITS - 1);
    localparam logic [3:0]        LAST_IDX  = 4'(FRAME_BITS - 1);
    // Timer value one clock before the final clock of STOP (CLKS_PER_BIT >= 2)
    localparam logic [TW-1:0]     STOP_PRE  = TW'((CLKS_PER_BIT > 1) ? CLKS_PER_BIT - 2 : 0);

    // Collector
    logic [FRAME_BITS-1:0] frame_buf;
    logic                  full;
    logic                  accept;
    logic                  handoff;

    // Serializer
    tx_state_t             state;
    logic [FRAME_BITS-1:0] tx_data;
    logic [3:0]            bit_idx;
    logic [TW-1:0]         bit_cnt;
    logic                  bit_end;
`ifdef BNN_TX_PARITY_EN
    logic                  parity_bit;
`endif

    assign res_ready = ~full;
    assign accept    = res_valid && !full;
    assign handoff   = full && (state == ST_IDLE);
    assign fsm_state = state;

    // Collector: shift accepted bits in from the top so the first bit ends up at bit 0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_buf  <= '0;
            fill_count <= '0;
            full       <= 1'b0;
        end else if (handoff) begin
            full       <= 1'b0;
            fill_count <= '0;
        end else if (accept) begin
            frame_buf  <= {res_bit, frame_buf[FRAME_BITS-1:1]};
            fill_count <= fill_count + 5'd1;
            if (fill_count == FILL_LAST) begin
                full <= 1'b1;
            end
        end
    end

    // Bit timer runs in every non-IDLE state and is held cleared in IDLE
    bnn_tx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (state == ST_IDLE),
        .enable  (state != ST_IDLE),
        .count   (bit_cnt),
        .bit_end (bit_end)
    );

    // Serializer FSM with registered line, busy and frame_done outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            tx_out     <= 1'b1;
            tx_busy    <= 1'b0;
            frame_done <= 1'b0;
            tx_data    <= '0;
            bit_idx    <= '0;
`ifdef BNN_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (handoff) begin
                        state   <= ST_START;
                        tx_data <= frame_buf;
                        tx_out  <= 1'b0;
                        tx_busy <= 1'b1;
`ifdef BNN_TX_PARITY_EN
                        parity_bit <= ^frame_buf;
`endif
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        state   <= ST_DATA;
                        bit_idx <= '0;
                        tx_out  <= tx_data[0];
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        if (bit_idx == LAST_IDX) begin
`ifdef BNN_TX_PARITY_EN
                            state  <= ST_PARITY;
                            tx_out <= parity_bit;
`else
                            state  <= ST_STOP;
                            tx_out <= 1'b1;
                            // A one-clock stop bit is its own last cycle
                            if (CLKS_PER_BIT == 1) begin
                                frame_done <= 1'b1;
                            end
`endif
                        end else begin
                            // Shift so the next frame bit is always at position 0
                            bit_idx <= bit_idx + 4'd1;
                            tx_data <= tx_data >> 1;
                            tx_out  <= tx_data[1];
                        end
                    end
                end
`ifdef BNN_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end) begin
                        state  <= ST_STOP;
                        tx_out <= 1'b1;
                        if (CLKS_PER_BIT == 1) begin
                            frame_done <= 1'b1;
                        end
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_end) begin
                        // A waiting full collector is handed off on the next edge,
                        // which leaves exactly one idle-high cycle between frames
                        state   <= ST_IDLE;
                        tx_busy <= 1'b0;
                        tx_out  <= 1'b1;
                    end else if (bit_cnt == STOP_PRE) begin
                        frame_done <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    tx_out  <= 1'b1;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_result_tx.sv
// Self-checking bench for bnn_result_tx. A default instance (8 bits,
// 4 clocks/bit) is checked by a line receiver against a frame scoreboard;
// a small instance (2 bits, 1 clock/bit) is checked cycle by cycle.
// Honours BNN_TX_PARITY_EN when the build defines it.
module tb_bnn_result_tx;

    localparam int FB  = 8;
    localparam int CPB = 4;
`ifdef BNN_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main DUT ----------------
    logic       res_valid, res_bit, res_ready, tx_out, tx_busy, frame_done;
    logic [4:0] fill_count;
    logic [2:0] fsm_state;

    bnn_result_tx #(.FRAME_BITS(FB), .CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .res_valid  (res_valid),
        .res_bit    (res_bit),
        .res_ready  (res_ready),
        .tx_out     (tx_out),
        .tx_busy    (tx_busy),
        .frame_done (frame_done),
        .fill_count (fill_count),
        .fsm_state  (fsm_state)
    );

    // ---------------- small DUT ----------------
    logic       s_valid, s_bit, s_ready, s_tx, s_busy, s_done;
    logic [4:0] s_fill;
    logic [2:0] s_state;

    bnn_result_tx #(.FRAME_BITS(2), .CLKS_PER_BIT(1)) dut_small (
        .clk        (clk),
        .rst_n      (rst_n),
        .res_valid  (s_valid),
        .res_bit    (s_bit),
        .res_ready  (s_ready),
        .tx_out     (s_tx),
        .tx_busy    (s_busy),
        .frame_done (s_done),
        .fill_count (s_fill),
        .fsm_state  (s_state)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [FB-1:0] exp_q[$];
    logic [FB-1:0] acc_word;
    int            acc_n = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Record an accepted bit; every FB bits form one expected frame
    task automatic model_accept(input logic b);
        acc_word[acc_n] = b;
        acc_n++;
        if (acc_n == FB) begin
            exp_q.push_back(acc_word);
            acc_n = 0;
        end
    endtask

    // ---------------- line receiver ----------------
    logic          mon_en = 1'b1;
    int            rx_phase = 0;
    int            rx_cnt = 0;
    int            rx_idx = 0;
    logic [FB-1:0] rx_word;
    logic          rx_par;
    int            idle_run = 0;
    int            frames_rx = 0;
    int            gap_from = 1000000;

    task automatic finish_frame();
        logic [FB-1:0] e;
        if (exp_q.size() == 0) begin
            check_val("unexpected_frame", rx_word, 32'hFFFF_FFFF);
        end else begin
            e = exp_q.pop_front();
            check_val("frame", rx_word, e);
            if (PAR) check_val("parity", rx_par, ^e);
        end
        frames_rx++;
    endtask

    always @(negedge clk) begin
        if (!mon_en || !rst_n) begin
            rx_phase = 0;
            idle_run = 0;
        end else begin
            if (rx_phase != 0 && rx_cnt == CPB) begin
                rx_cnt = 0;
                case (rx_phase)
                    1: begin rx_phase = 2; rx_idx = 0; end
                    2: begin
                        if (rx_idx == FB - 1) rx_phase = PAR ? 3 : 4;
                        else rx_idx++;
                    end
                    3: rx_phase = 4;
                    default: begin finish_frame(); rx_phase = 0; idle_run = 0; end
                endcase
            end
            case (rx_phase)
                0: begin
                    if (tx_out === 1'b0) begin
                        if (frames_rx >= gap_from) check_val("frame_gap", idle_run, 1);
                        rx_phase = 1;
                        rx_cnt = 1;
                    end else begin
                        idle_run++;
                    end
                end
                1: begin check_val("start_bit", tx_out, 1'b0); rx_cnt++; end
                2: begin
                    if (rx_cnt == 0) rx_word[rx_idx] = tx_out;
                    else check_val("data_hold", tx_out, rx_word[rx_idx]);
                    rx_cnt++;
                end
                3: begin
                    if (rx_cnt == 0) rx_par = tx_out;
                    else check_val("parity_hold", tx_out, rx_par);
                    rx_cnt++;
                end
                default: begin
                    check_val("stop_bit", tx_out, 1'b1);
                    check_val("frame_done_stop", frame_done, rx_cnt == CPB - 1);
                    rx_cnt++;
                end
            endcase
            if (rx_phase != 4) check_val("frame_done_quiet", frame_done, 1'b0);
            check_val("busy", tx_busy, rx_phase != 0);
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic push_bit(input logic b, input int pre_gap, output int stall);
        int guard;
        repeat (pre_gap) @(negedge clk);
        res_valid = 1'b1;
        res_bit   = b;
        stall = 0;
        guard = 0;
        while (!res_ready && guard < 2000) begin
            @(negedge clk);
            stall++;
            guard++;
        end
        if (guard >= 2000) check_val("ready_timeout", 0, 1);
        model_accept(b);
        @(negedge clk);
        res_valid = 1'b0;
    endtask

    task automatic push_frame(input logic [FB-1:0] w, input int max_gap);
        int st;
        for (int i = 0; i < FB; i++) push_bit(w[i], $urandom_range(max_gap, 0), st);
    endtask

    task automatic wait_drain();
        int g = 0;
        while ((exp_q.size() != 0 || rx_phase != 0) && g < 3000) begin
            @(negedge clk);
            g++;
        end
        check_val("drain_timeout", g < 3000, 1'b1);
        repeat (3) @(negedge clk);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int st;
        int g;
        logic [5:0] s_line;
        logic [5:0] s_busy_exp;
        logic [5:0] s_done_exp;
        int s_busy_cnt;

        res_valid = 1'b0;
        res_bit   = 1'b0;
        s_valid   = 1'b0;
        s_bit     = 1'b0;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check_val("rst_tx_out", tx_out, 1'b1);
        check_val("rst_busy", tx_busy, 1'b0);
        check_val("rst_frame_done", frame_done, 1'b0);
        check_val("rst_fill", fill_count, 5'd0);
        check_val("rst_ready", res_ready, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);

        // Small instance: bits 1,1 at one clock per bit
`ifdef BNN_TX_PARITY_EN
        s_line = 6'b110110; s_busy_exp = 6'b011111; s_done_exp = 6'b010000;
`else
        s_line = 6'b111110; s_busy_exp = 6'b001111; s_done_exp = 6'b001000;
`endif
        s_valid = 1'b1;
        s_bit   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        check_val("small_full_fill", s_fill, 5'd2);
        check_val("small_ready_low", s_ready, 1'b0);
        s_busy_cnt = 0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            check_val("small_line", s_tx, s_line[j]);
            check_val("small_busy", s_busy, s_busy_exp[j]);
            check_val("small_done", s_done, s_done_exp[j]);
            if (s_busy) s_busy_cnt++;
        end
        check_val("small_busy_cycles", s_busy_cnt, PAR ? 5 : 4);

        // Frame 0x4D back to back, with start-bit latency
        for (int i = 0; i < FB; i++) push_bit(st == -1 ? 1'b0 : 8'h4D >> i, 0, st);
        check_val("pre_start_line", tx_out, 1'b1);
        check_val("full_fill", fill_count, 5'd8);
        check_val("full_ready", res_ready, 1'b0);
        @(negedge clk);
        check_val("start_latency", tx_out, 1'b0);
        check_val("handoff_fill", fill_count, 5'd0);
        wait_drain();

        // Frame 0x4F (odd number of ones) and a few random frames with gaps
        push_frame(8'h4F, 0);
        wait_drain();
        for (int k = 0; k < 3; k++) push_frame(8'($urandom_range(255, 0)), 2);
        wait_drain();

        // Continuous 24-bit stream: three frames, one idle cycle apart
        gap_from = frames_rx + 1;
        for (int i = 0; i < 24; i++) begin
            push_bit(1'($urandom_range(1, 0)), 0, st);
            if (i > 8 && i < 16) check_val("stream_no_stall", st, 0);
            if (i == 16) check_val("stream_stall_b16", st > 0, 1'b1);
            if (i > 16) check_val("stream_no_stall2", st, 0);
        end
        wait_drain();
        gap_from = 1000000;

        // Reset during DATA slot 3 with a partly filled collector
        push_frame(8'hA5, 0);
        for (int i = 0; i < 3; i++) push_bit(1'b1, 0, st);
        g = 0;
        while (!(rx_phase == 2 && rx_idx == 3) && g < 500) begin
            @(negedge clk);
            g++;
        end
        check_val("slot3_timeout", g < 500, 1'b1);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_val("midrst_tx_out", tx_out, 1'b1);
        check_val("midrst_fill", fill_count, 5'd0);
        check_val("midrst_busy", tx_busy, 1'b0);
        check_val("midrst_ready", res_ready, 1'b1);
        exp_q.delete();
        acc_n = 0;
        @(negedge clk);
        check_val("midrst_idle_line", tx_out, 1'b1);
        mon_en = 1'b1;
        push_frame(8'h3C, 0);
        wait_drain();

        // res_valid toggling every other cycle
        for (int i = 0; i < FB; i++) begin
            check_val("tog_ready", res_ready, 1'b1);
            res_valid = 1'b1;
            res_bit   = 1'((8'hC6 >> i) & 1);
            model_accept(res_bit);
            @(negedge clk);
            res_valid = 1'b0;
            check_val("tog_fill", fill_count, 5'(i + 1));
            if (i < FB - 1) begin
                @(negedge clk);
                check_val("tog_fill_hold", fill_count, 5'(i + 1));
                check_val("tog_line_idle", tx_out, 1'b1);
            end
        end
        @(negedge clk);
        check_val("tog_start", tx_out, 1'b0);
        check_val("tog_fill_clear", fill_count, 5'd0);
        wait_drain();

        check_val("all_frames_seen", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
